// File: rtl/des_ip_loader_if.sv
//------------------------------------------------------------------------------
// Module   : des_ip_loader_if
// Brief    : Byte-in / permuted-block-out handshake bundle for des_ip_loader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface des_ip_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] left_half;
    logic [31:0] right_half;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, left_half, right_half, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, left_half, right_half, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/des_ip_loader.sv
//------------------------------------------------------------------------------
// Module   : des_ip_loader
// Brief    : Collects a 64-bit DES text block byte-serially and registers its
//            Initial Permutation as left/right halves for the round datapath.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module des_ip_loader #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       abort,
    des_ip_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // DES IP table, output bit i+1 takes input bit c_ip_table[i] (bit 1 = MSB).
    localparam int c_ip_table [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [55:0] shift_q, shift_d;
    logic [31:0] left_q, left_d;
    logic [31:0] right_q, right_d;

    logic        w_accept;
    logic [63:0] w_block;
    logic [63:0] w_ip;

    // Only 7 bytes are stored; the 8th completes the block combinationally.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_block = {shift_q, bus.in_data};
        end else begin : g_lsb_first
            assign w_block = {bus.in_data, shift_q};
        end
    endgenerate

    generate
        for (genvar i = 0; i < 64; i++) begin : g_ip
            localparam int SRC = 64 - c_ip_table[i];
            assign w_ip[63 - i] = w_block[SRC];
        end
    endgenerate

    assign w_accept       = bus.in_valid && (state_q == S_LOAD);
    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.left_half  = left_q;
    assign bus.right_half = right_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        left_d  = left_q;
        right_d = right_q;

        if (abort) begin
            state_d = S_LOAD;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_INIT: state_d = S_LOAD;
                S_LOAD: begin
                    if (w_accept) begin
                        cnt_d   = cnt_q + 3'd1;
                        shift_d = MSB_FIRST ? w_block[55:0] : w_block[63:8];
                        if (cnt_q == 3'd7) begin
                            state_d = S_HOLD;
                            left_d  = w_ip[63:32];
                            right_d = w_ip[31:0];
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) state_d = S_LOAD;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= 3'd0;
            shift_q <= 56'd0;
            left_q  <= 32'd0;
            right_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/des_ip_loader.md
# des_ip_loader

Byte-serial input stage of the DES datapath. It accepts a 64-bit text block one byte at a time over a valid/ready handshake and applies the standard DES Initial Permutation (IP). It presents the permuted block as `left_half`/`right_half` to the round datapath over a second valid/ready handshake. It is the entry counterpart of `Final_Permutation`: for any 64-bit x, feeding `left_half`/`right_half` into `Final_Permutation` returns x.

## Interface
- `MSB_FIRST`, default 1: 1 means the first accepted byte is text bits [63:56]; 0 means the first accepted byte is bits [7:0].
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `abort`, input, 1: synchronous flush of any partial or held block.
- `in_data`, input, 8: text byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a byte this cycle.
- `left_half`, output, 32: IP output bits 1..32 (DES numbering, bit 1 = MSB).
- `right_half`, output, 32: IP output bits 33..64.
- `out_valid`, output, 1: `left_half`/`right_half` hold a complete permuted block.
- `out_ready`, input, 1: downstream accepts the block.

## Operation
- FSM states are INIT, LOAD and HOLD.
  - INIT goes to LOAD unconditionally on the next clock.
  - LOAD goes to HOLD when the 8th byte is accepted.
  - HOLD goes to LOAD on the output handshake.
  - From any state, `abort` forces LOAD with the byte count cleared.
- `in_ready` = (state == LOAD). `out_valid` = (state == HOLD).
- A byte is accepted when `in_valid && in_ready`. A 3-bit counter (0..7) tracks the byte position.
  - The byte goes into a 64-bit shift register in the order selected by `MSB_FIRST`.
  - The counter wraps to 0 after the 8th byte.
- On the 8th accept, the IP of the completed 64-bit block is registered into `left_half`/`right_half`.
  - IP is the standard DES table: output bit i = input bit IP[i], with bit 1 = MSB (bit 63).
  - The table begins 58 50 42 34 26 18 10 2 / 60 52 … and ends … 63 55 47 39 31 23 15 7.
  - The permutation is pure wiring; there is no arithmetic.
- The output handshake occurs when `out_valid && out_ready`. After it, the outputs keep their last value; they are not cleared.
- `abort` has priority over a simultaneous byte accept or output handshake. The bytes and block are discarded and `out_valid` drops on the next cycle. `left_half`/`right_half` are not cleared.
- Reset applies immediately regardless of the clock:
  - state INIT, counter 0, shift register 0;
  - `left_half` and `right_half` are 0;
  - `in_ready` and `out_valid` are 0.
- Reset asserted mid-block discards the partial block; no output is produced for it.

## Timing
- Latency: `out_valid` is high in the cycle after the edge that accepts the 8th byte.
- `in_ready` is first high in the second cycle after `rst_n` deasserts (one INIT cycle).
- In HOLD, `in_ready` is 0, so no byte is accepted while a block is pending. The block stays stable until `out_ready`.
- After the output handshake edge, `in_ready` is 1 in the next cycle. Minimum period is 9 cycles per block (8 loads + 1 handshake).
- `in_valid` deasserted mid-block stalls the load; the counter and shift register hold.
- `out_ready` held high in LOAD has no effect.

## Test plan
- Known vector, `MSB_FIRST`=1:
  - Stimulus: bytes 01 23 45 67 89 AB CD EF, back-to-back.
  - Required: `left_half`=CC00CCFF and `right_half`=F0AAF0AA, with `out_valid` high exactly 1 cycle after the 8th accept.
- Round trip: outputs fed to `Final_Permutation` return 0123456789ABCDEF. Run 100 random blocks, each with a random `in_valid` gap pattern; every block must round-trip.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after a block completes.
  - Required: outputs stable, `in_ready`=0, and bytes offered on `in_data` are not consumed.
  - On the `out_ready` pulse: `out_valid` falls and `in_ready` rises in the next cycle.
- Boundary blocks: all-zero bytes give 00000000/00000000; all-FF bytes give FFFFFFFF/FFFFFFFF.
- Abort and reset:
  - `abort` after 5 bytes, then a fresh 8-byte block of 0123456789ABCDEF: required output is CC00CCFF/F0AAF0AA, with the partial data ignored.
  - `rst_n` pulsed low mid-block: all outputs are 0 immediately.
- `MSB_FIRST`=0: bytes EF CD AB 89 67 45 23 01 give CC00CCFF/F0AAF0AA.
